// File: rtl/maxpool_row_pair_buffer.sv
// +-------------------------------------------------------------------------+
// | maxpool_row_pair_buffer                                                 |
// | Buffers each even row of a raster pixel stream and, on the following    |
// | odd row, emits vertically aligned (upper, lower) pixel pairs for a 2x2  |
// | max-pool stage.                                                         |
// | Optional macro: MAXPOOL_RELU_EN clamps negative input pixels to zero.   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module maxpool_row_pair_buffer #(
    parameter int dataColNum = 28,
    parameter int dataRowNum = 28,
    parameter int wordlength = 16
) (
    input  logic                         clk,
    input  logic                         irst_n,
    input  logic                         in_valid,
    input  logic signed [wordlength-1:0] pixel_in,
    output logic signed [wordlength-1:0] pixels_0,
    output logic signed [wordlength-1:0] pixels_1,
    output logic                         out_valid,
    output logic                         frame_done
);

    localparam int C_COL_W = (dataColNum > 1) ? $clog2(dataColNum) : 1;
    localparam int C_ROW_W = (dataRowNum > 1) ? $clog2(dataRowNum) : 1;
    localparam logic [C_COL_W-1:0] C_LAST_COL = C_COL_W'(dataColNum - 1);
    localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(dataRowNum - 1);
    localparam logic C_ODD_COLS = ((dataColNum % 2) != 0);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_PAIR = 1'b1;

    logic [C_COL_W-1:0]           r_col;
    logic [C_ROW_W-1:0]           r_row;
    logic [0:0]                   r_state;
    logic signed [wordlength-1:0] r_buf [dataColNum];

    logic signed [wordlength-1:0] w_pix;
    logic                         w_last_col;
    logic                         w_last_row;
    logic                         w_emit;

`ifdef MAXPOOL_RELU_EN
    assign w_pix = pixel_in[wordlength-1] ? '0 : pixel_in;
`else
    assign w_pix = pixel_in;
`endif

    assign w_last_col = (r_col == C_LAST_COL);
    assign w_last_row = (r_row == C_LAST_ROW);
    // An odd trailing column has no horizontal partner, so it is never paired.
    assign w_emit     = in_valid && (r_state == S_PAIR) && !(C_ODD_COLS && w_last_col);

    always_ff @(posedge clk) begin
        if (irst_n && in_valid && (r_state == S_FILL)) begin
            r_buf[r_col] <= w_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!irst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_state    <= S_FILL;
            pixels_0   <= '0;
            pixels_1   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= w_emit;
            frame_done <= in_valid && w_last_col && w_last_row;
            if (w_emit) begin
                pixels_0 <= r_buf[r_col];
                pixels_1 <= w_pix;
            end
            if (in_valid) begin
                if (w_last_col) begin
                    r_col <= '0;
                    // Frame end always returns to FILL, covering an odd row count.
                    if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= S_FILL;
                    end else begin
                        r_row   <= r_row + 1'b1;
                        r_state <= (r_state == S_FILL) ? S_PAIR : S_FILL;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_row_pair_buffer.sv
// +-------------------------------------------------------------------------+
// | tb_maxpool_row_pair_buffer                                              |
// | Directed self-checking bench: a 4x4 and a 5x3 instance side by side.    |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_maxpool_row_pair_buffer;

    logic               clk;
    logic               rstn [2];
    logic               iv   [2];
    logic signed [15:0] ipx  [2];
    logic signed [15:0] p0   [2];
    logic signed [15:0] p1   [2];
    logic               ov   [2];
    logic               fd   [2];

    int n_chk  = 0;
    int n_pass = 0;
    int h0 [2] = '{0, 0};
    int h1 [2] = '{0, 0};

    maxpool_row_pair_buffer #(
        .dataColNum(4), .dataRowNum(4), .wordlength(16)
    ) dut_a (
        .clk(clk), .irst_n(rstn[0]), .in_valid(iv[0]), .pixel_in(ipx[0]),
        .pixels_0(p0[0]), .pixels_1(p1[0]), .out_valid(ov[0]), .frame_done(fd[0])
    );

    maxpool_row_pair_buffer #(
        .dataColNum(5), .dataRowNum(3), .wordlength(16)
    ) dut_b (
        .clk(clk), .irst_n(rstn[1]), .in_valid(iv[1]), .pixel_in(ipx[1]),
        .pixels_0(p0[1]), .pixels_1(p1[1]), .out_valid(ov[1]), .frame_done(fd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_outs(input int d, input string tag, input int exp_v, input int exp_fd);
        check($sformatf("%s dut%0d out_valid", tag, d), int'(ov[d]), exp_v);
        check($sformatf("%s dut%0d pixels_0", tag, d), int'(p0[d]), h0[d]);
        check($sformatf("%s dut%0d pixels_1", tag, d), int'(p1[d]), h1[d]);
        check($sformatf("%s dut%0d frame_done", tag, d), int'(fd[d]), exp_fd);
    endtask

    task automatic push(input int d, input int v, input int emit, input int e0, input int e1,
                        input int lastpix, input string tag);
        iv[d]  = 1'b1;
        ipx[d] = 16'(v);
        @(posedge clk); #1;
        iv[d]  = 1'b0;
        if (emit != 0) begin
            h0[d] = e0;
            h1[d] = e1;
        end
        check_outs(d, tag, emit, lastpix);
    endtask

    task automatic idle(input int d, input string tag);
        @(posedge clk); #1;
        check_outs(d, tag, 0, 0);
    endtask

    task automatic do_reset(input int d, input string tag);
        rstn[d] = 1'b0;
        iv[d]   = 1'b0;
        @(posedge clk); #1;
        rstn[d] = 1'b1;
        h0[d]   = 0;
        h1[d]   = 0;
        check_outs(d, tag, 0, 0);
    endtask

    // Pixel value is 10*row+col; pairs appear only on odd rows, and never for a
    // trailing odd column.
    task automatic run_frame(input int d, input int cols, input int rows, input bit gaps,
                             input string tag);
        int pairs = 0;
        int fds   = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                int emit;
                emit = ((r % 2) == 1 && !((cols % 2) == 1 && c == cols - 1)) ? 1 : 0;
                if (gaps) idle(d, {tag, " gap"});
                push(d, 10 * r + c, emit, 10 * (r - 1) + c, 10 * r + c,
                     (r == rows - 1 && c == cols - 1) ? 1 : 0,
                     $sformatf("%s r%0d c%0d", tag, r, c));
                pairs += int'(ov[d]);
                fds   += int'(fd[d]);
            end
        end
        check($sformatf("%s dut%0d pair count", tag, d), pairs, (rows / 2) * ((cols / 2) * 2));
        check($sformatf("%s dut%0d frame_done count", tag, d), fds, 1);
    endtask

    initial begin
        int n0 [4] = '{-5, -32768, 7, 0};
        int n1 [4] = '{3, -1, -32768, 32767};

        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            iv[d]   = 1'b0;
            ipx[d]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_outs(d, "reset", 0, 0);
            rstn[d] = 1'b1;
        end

        // Basic frame followed immediately by a second one, then a gapped frame.
        run_frame(0, 4, 4, 1'b0, "basic");
        run_frame(0, 4, 4, 1'b0, "b2b");
        run_frame(0, 4, 4, 1'b1, "gaps");

        // Partial frame up to (1,2), then reset and restart cleanly.
        for (int c = 0; c < 4; c++) push(0, c, 0, 0, 0, 0, "partial r0");
        for (int c = 0; c < 3; c++) push(0, 10 + c, 1, c, 10 + c, 0, "partial r1");
        do_reset(0, "midreset");
        run_frame(0, 4, 4, 1'b0, "after reset");

        // Signed extremes, with optional clamping of negatives.
        for (int c = 0; c < 4; c++) push(0, n0[c], 0, 0, 0, 0, "neg r0");
        for (int c = 0; c < 4; c++)
            push(0, n1[c], 1, relu(n0[c]), relu(n1[c]), 0, $sformatf("neg c%0d", c));
        do_reset(0, "neg reset");

        // Odd geometry: 5 columns, 3 rows.
        run_frame(1, 5, 3, 1'b0, "odd");
        run_frame(1, 5, 3, 1'b1, "odd gaps");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
